// File: rtl/maple_transmitter.sv
// Maple Bus frame transmitter: AXI-Stream bytes in, SDCKA/SDCKB frames out.
// One holding byte feeds a shift register; each bus phase lasts CLKS_PER_PHASE cycles.
module maple_transmitter #(
    parameter int CLKS_PER_PHASE = 25,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    input  logic                  ENABLE,
    output logic                  SDCKA_O,
    output logic                  SDCKB_O,
    output logic                  SDCK_OE,
    output logic                  TRANSMITTING,
    output logic                  UNDERRUN
);

    localparam int CW = (CLKS_PER_PHASE > 1) ? $clog2(CLKS_PER_PHASE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_PHASE - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_END   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            ph_q, ph_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_last_q, hold_last_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  sh_last_q, sh_last_d;
    logic                  seen_q, seen_d;
    logic                  under_q, under_d;

    logic tick;
    logic beat;
    logic a_o, b_o, oe_o;

    assign tick = (cnt_q == CNT_MAX);
    assign beat = S_AXIS_TVALID && S_AXIS_TREADY;

    assign S_AXIS_TREADY = aresetn && !hold_vld_q && !seen_q &&
                           (((state_q == ST_IDLE) && ENABLE) ||
                            (state_q == ST_START) ||
                            (state_q == ST_DATA));
    assign TRANSMITTING  = (state_q != ST_IDLE);
    assign UNDERRUN      = under_q;
    assign SDCKA_O       = a_o;
    assign SDCKB_O       = b_o;
    assign SDCK_OE       = oe_o;

    // Next-state: beat capture, phase timing, frame sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_vld_d  = hold_vld_q;
        sh_d        = sh_q;
        sh_last_d   = sh_last_q;
        seen_d      = seen_q;
        under_d     = 1'b0;

        if (beat) begin
            hold_d      = S_AXIS_TDATA;
            hold_last_d = S_AXIS_TLAST;
            hold_vld_d  = 1'b1;
            seen_d      = seen_q | S_AXIS_TLAST;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                ph_d  = 4'd0;
                if (beat) state_d = ST_START;
            end
            ST_START: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (ph_q == 4'd8) begin
                        state_d    = ST_DATA;
                        ph_d       = 4'd0;
                        sh_d       = hold_q;
                        sh_last_d  = hold_last_q;
                        hold_vld_d = 1'b0;
                    end else begin
                        ph_d = ph_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (ph_q == 4'd15) begin
                        ph_d = 4'd0;
                        if (sh_last_q) begin
                            state_d = ST_END;
                        end else if (hold_vld_q) begin
                            sh_d       = hold_q;
                            sh_last_d  = hold_last_q;
                            hold_vld_d = 1'b0;
                        end else begin
                            under_d = 1'b1;
                            state_d = ST_END;
                        end
                    end else begin
                        ph_d = ph_q + 4'd1;
                        if (ph_q[0]) sh_d = {sh_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_END: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (ph_q == 4'd5) begin
                        state_d = ST_DONE;
                        ph_d    = 4'd0;
                    end else begin
                        ph_d = ph_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ph_d    = 4'd0;
                seen_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line levels decoded from state, phase index and the current data bit.
    always_comb begin
        a_o  = 1'b1;
        b_o  = 1'b1;
        oe_o = 1'b0;
        unique case (state_q)
            ST_START: begin
                oe_o = 1'b1;
                a_o  = 1'b0;
                b_o  = ~ph_q[0];
            end
            ST_DATA: begin
                oe_o = 1'b1;
                if (!ph_q[1]) begin
                    a_o = ~ph_q[0];
                    b_o = sh_q[DATA_WIDTH-1];
                end else begin
                    a_o = sh_q[DATA_WIDTH-1];
                    b_o = ~ph_q[0];
                end
            end
            ST_END: begin
                oe_o = 1'b1;
                a_o  = (ph_q == 4'd5) | ~ph_q[0];
                b_o  = (ph_q == 4'd5);
            end
            default: begin
                oe_o = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ph_q        <= 4'd0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            sh_q        <= '0;
            sh_last_q   <= 1'b0;
            seen_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_vld_q  <= hold_vld_d;
            sh_q        <= sh_d;
            sh_last_q   <= sh_last_d;
            seen_q      <= seen_d;
            under_q     <= under_d;
        end
    end

endmodule

// File: tb/tb_maple_transmitter.sv
// Bench for maple_transmitter: gating table, directed frames, random frames.
// Expected bus traces are built phase by phase from the frame rules.
module tb_maple_transmitter;

    localparam int CPP = 4;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       enable = 1'b0;
    logic       tready, sa, sb, oe, trans, under;

    int errs = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    maple_transmitter #(.CLKS_PER_PHASE(CPP), .DATA_WIDTH(8)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .S_AXIS_TDATA(tdata),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TLAST(tlast),
        .S_AXIS_TREADY(tready),
        .ENABLE(enable),
        .SDCKA_O(sa),
        .SDCKB_O(sb),
        .SDCK_OE(oe),
        .TRANSMITTING(trans),
        .UNDERRUN(under)
    );

    typedef struct packed {
        logic tr;
        logic oe;
        logic a;
        logic b;
        logic un;
    } smp_t;

    typedef struct {
        bit rst;
        bit en;
        bit tv;
        logic [5:0] exp;
    } vec_t;

    smp_t exp_q[$];
    smp_t obs_q[$];

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic smp_t smp();
        smp_t s;
        s.tr = trans;
        s.oe = oe;
        s.a  = sa;
        s.b  = sb;
        s.un = under;
        return s;
    endfunction

    function automatic void build(input byte unsigned b[$], input bit ur);
        logic [1:0] ph[$];
        smp_t s;
        int n;
        n = b.size();
        exp_q.delete();
        ph.push_back(2'b01);
        for (int k = 1; k <= 8; k++) ph.push_back({1'b0, (k % 2 == 0)});
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                logic v;
                v = b[i][k];
                if (k % 2 == 1) begin
                    ph.push_back({1'b1, v});
                    ph.push_back({1'b0, v});
                end else begin
                    ph.push_back({v, 1'b1});
                    ph.push_back({v, 1'b0});
                end
            end
        end
        ph.push_back(2'b10);
        ph.push_back(2'b00);
        ph.push_back(2'b10);
        ph.push_back(2'b00);
        ph.push_back(2'b10);
        ph.push_back(2'b11);
        for (int p = 0; p < ph.size(); p++) begin
            for (int c = 0; c < CPP; c++) begin
                s.tr = 1'b1;
                s.oe = 1'b1;
                s.a  = ph[p][1];
                s.b  = ph[p][0];
                s.un = ur && (p == 9 + 16 * n) && (c == 0);
                exp_q.push_back(s);
            end
        end
        exp_q.push_back(smp_t'(5'b10110));
        exp_q.push_back(smp_t'(5'b00110));
    endfunction

    function automatic int falls_of(input bit use_obs);
        int f;
        logic pa, pb;
        smp_t s;
        f = 0;
        pa = 1'b1;
        pb = 1'b1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (use_obs && j >= obs_q.size()) break;
            s = use_obs ? obs_q[j] : exp_q[j];
            if (pa === 1'b1 && s.a === 1'b0) f++;
            if (pb === 1'b1 && s.b === 1'b0) f++;
            pa = s.a;
            pb = s.b;
        end
        return f;
    endfunction

    task automatic step(output bit hs);
        #1 hs = tvalid && (tready === 1'b1);
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic frame(input byte unsigned b[$], input bit ur, input int abort_j);
        int n, bi, c0, total, badrdy, mism, first;
        int acc[$];
        bit hs;
        n = b.size();
        bi = 0;
        c0 = -1;
        badrdy = 0;
        build(b, ur);
        total = exp_q.size();
        obs_q.delete();
        enable = 1'b1;
        tvalid = 1'b1;
        tdata = b[0];
        tlast = (n == 1) && !ur;
        for (int c = 0; c < 2000; c++) begin
            step(hs);
            if (hs) begin
                acc.push_back(c);
                if (c0 < 0) c0 = c;
                bi++;
                if (bi < n) begin
                    tdata = b[bi];
                    tlast = (bi == n - 1) && !ur;
                end else begin
                    tvalid = 1'b0;
                    tlast = 1'b0;
                end
            end
            if (c0 >= 0) begin
                obs_q.push_back(smp());
                if (!ur && bi == n && obs_q.size() <= total - 1 && tready !== 1'b0)
                    badrdy++;
                if (obs_q.size() - 1 == abort_j) break;
                if (obs_q.size() == total) break;
            end
        end
        chk("first_accept", (c0 >= 0), 1);
        if (c0 < 0) begin
            tvalid = 1'b0;
            return;
        end
        if (abort_j >= 0) begin
            aresetn = 1'b0;
            tvalid = 1'b0;
            tlast = 1'b0;
            step(hs);
            chk("mid_reset", {tready, trans, oe, sa, sb}, 5'b00011);
            aresetn = 1'b1;
            step(hs);
            return;
        end
        chk("frame_len", obs_q.size(), total);
        mism = 0;
        first = -1;
        for (int j = 0; j < obs_q.size(); j++) begin
            if (obs_q[j] !== exp_q[j]) begin
                mism++;
                if (first < 0) first = j;
            end
        end
        if (first >= 0)
            chk($sformatf("trace@%0d", first), obs_q[first], exp_q[first]);
        else
            chk("trace", mism, 0);
        mism = 0;
        foreach (obs_q[j]) if (obs_q[j].oe === 1'b1) mism++;
        chk("oe_cycles", mism, (9 + 16 * n + 6) * CPP);
        chk("falls", falls_of(1'b1), falls_of(1'b0));
        chk("accepts", acc.size(), n);
        for (int k = 1; k < acc.size(); k++)
            chk($sformatf("accept_%0d", k), acc[k] - c0,
                9 * CPP + 1 + 16 * CPP * (k - 1));
        if (!ur) chk("tready_after_tlast", badrdy, 0);
    endtask

    initial begin
        vec_t tbl[7];
        byte unsigned q[$];
        bit hs;
        int bad;

        tbl[0] = '{rst: 1'b0, en: 1'b1, tv: 1'b1, exp: 6'b000110};
        tbl[1] = '{rst: 1'b0, en: 1'b0, tv: 1'b0, exp: 6'b000110};
        tbl[2] = '{rst: 1'b1, en: 1'b0, tv: 1'b1, exp: 6'b000110};
        tbl[3] = '{rst: 1'b1, en: 1'b0, tv: 1'b0, exp: 6'b000110};
        tbl[4] = '{rst: 1'b1, en: 1'b1, tv: 1'b0, exp: 6'b100110};
        tbl[5] = '{rst: 1'b1, en: 1'b0, tv: 1'b1, exp: 6'b000110};
        tbl[6] = '{rst: 1'b0, en: 1'b1, tv: 1'b0, exp: 6'b000110};

        aresetn = 1'b0;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < 7; i++) begin
            logic rdy;
            aresetn = tbl[i].rst;
            enable = tbl[i].en;
            tvalid = tbl[i].tv;
            tdata = 8'hEE;
            tlast = 1'b0;
            #1 rdy = tready;
            @(posedge aclk);
            @(negedge aclk);
            chk($sformatf("table_%0d", i), {rdy, trans, oe, sa, sb, under}, tbl[i].exp);
        end

        aresetn = 1'b1;
        enable = 1'b0;
        tvalid = 1'b1;
        tdata = 8'hA5;
        tlast = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(hs);
            if (tready !== 1'b0 || oe !== 1'b0) bad++;
        end
        chk("enable_low_hold", bad, 0);

        q = '{8'hA5};
        frame(q, 1'b0, -1);
        q = '{8'h01, 8'h80, 8'hFF};
        frame(q, 1'b0, -1);
        q = '{8'h3C};
        frame(q, 1'b1, -1);
        q = '{8'h11, 8'h22};
        frame(q, 1'b0, (9 + 16) * CPP + 5);
        q = '{8'h5A};
        frame(q, 1'b0, -1);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 3);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(byte'($urandom_range(0, 255)));
            enable = 1'b1;
            tvalid = 1'b0;
            repeat ($urandom_range(0, 3)) step(hs);
            frame(q, ($urandom_range(0, 3) == 0), -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
